// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10,
    TURN = 2'b11
  } arb_state_t;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int HOLD_CNT_W      = 8;

  function automatic logic other_master(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant handshake bundle between the two bus masters and the arbiter.
interface bus_arbiter_if;

  logic m1_req;
  logic m2_req;
  logic m1_done;
  logic m2_done;
  logic m1_grant;
  logic m2_grant;
  logic msel;
  logic bus_busy;
  logic timeout_err;

  modport slave (
    input  m1_req, m2_req, m1_done, m2_done,
    output m1_grant, m2_grant, msel, bus_busy, timeout_err
  );

  modport master (
    output m1_req, m2_req, m1_done, m2_done,
    input  m1_grant, m2_grant, msel, bus_busy, timeout_err
  );

endinterface

// File: rtl/bus_arb_timer.sv
// Saturating 8-bit hold counter; expired flags the last cycle a master may keep the bus.
module bus_arb_timer
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [HOLD_CNT_W-1:0] LIMIT   = HOLD_CNT_W'(TIMEOUT - 1);
  localparam logic [HOLD_CNT_W-1:0] CNT_MAX = {HOLD_CNT_W{1'b1}};

  logic [HOLD_CNT_W-1:0] r_cnt;

  // Hold counter: zero outside a grant, counts grant cycles, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {HOLD_CNT_W{1'b0}};
    end else if (clr) begin
      r_cnt <= {HOLD_CNT_W{1'b0}};
    end else if (en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = en && (r_cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with hold timeout and one-cycle turnaround.
// Define ARB_ROUND_ROBIN_EN to alternate masters on simultaneous requests (default: m1 wins).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  arb
);

  arb_state_t r_state;
  logic       r_m1_grant;
  logic       r_m2_grant;
  logic       r_msel;
  logic       r_bus_busy;
  logic       r_timeout_err;

  logic       w_in_grant;
  logic       w_expired;
  logic       w_tie_pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic       r_last_owner;
  assign w_tie_pick = other_master(r_last_owner);
`else
  assign w_tie_pick = M1;
`endif

  assign w_in_grant = (r_state == GNT1) || (r_state == GNT2);

  bus_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!w_in_grant),
    .en      (w_in_grant),
    .expired (w_expired)
  );

  // Arbitration FSM; all bus-facing outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_m1_grant    <= 1'b0;
      r_m2_grant    <= 1'b0;
      r_msel        <= M1;
      r_bus_busy    <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner  <= M2;
`endif
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (arb.m1_req && (!arb.m2_req || (w_tie_pick == M1))) begin
            r_state    <= GNT1;
            r_m1_grant <= 1'b1;
            r_msel     <= M1;
            r_bus_busy <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= M1;
`endif
          end else if (arb.m2_req) begin
            r_state    <= GNT2;
            r_m2_grant <= 1'b1;
            r_msel     <= M2;
            r_bus_busy <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= M2;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        GNT1: begin
          // A done or request drop in the timeout cycle is a normal release.
          if (arb.m1_done || !arb.m1_req || w_expired) begin
            r_state       <= TURN;
            r_m1_grant    <= 1'b0;
            r_timeout_err <= w_expired && !arb.m1_done && arb.m1_req;
          end else begin
            r_state <= GNT1;
          end
        end
        GNT2: begin
          if (arb.m2_done || !arb.m2_req || w_expired) begin
            r_state       <= TURN;
            r_m2_grant    <= 1'b0;
            r_timeout_err <= w_expired && !arb.m2_done && arb.m2_req;
          end else begin
            r_state <= GNT2;
          end
        end
        TURN: begin
          r_state    <= IDLE;
          r_bus_busy <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_m1_grant <= 1'b0;
          r_m2_grant <= 1'b0;
          r_bus_busy <= 1'b0;
        end
      endcase
    end
  end

  assign arb.m1_grant    = r_m1_grant;
  assign arb.m2_grant    = r_m2_grant;
  assign arb.msel        = r_msel;
  assign arb.bus_busy    = r_bus_busy;
  assign arb.timeout_err = r_timeout_err;

endmodule
